// File: rtl/jt89_pkg.sv
// Shared constants and sizing helpers for the jt89 I2S transmitter.
// Contents:
//   SND_W      width of the PSG mixed sample (signed, two's complement)
//   cnt_w()    bit width of the bclk half-period divider counter
//   idx_w()    bit width of the frame bit index (0 .. 2*WORD-1)
package jt89_pkg;

  localparam int SND_W = 12;

  function automatic int cnt_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

  function automatic int idx_w(input int word);
    return $clog2(2 * word);
  endfunction

endpackage

// File: rtl/jt89_i2s_tx_if.sv
// Sample handshake between the PSG mixer (master) and the I2S transmitter (slave).
// Signals:
//   sound      signed 12-bit sample
//   snd_valid  sample valid this cycle
//   snd_ready  transmitter buffer empty; transfer when snd_valid && snd_ready
interface jt89_i2s_tx_if import jt89_pkg::*; ();

  logic signed [SND_W-1:0] sound;
  logic                    snd_valid;
  logic                    snd_ready;

  modport master (output sound, output snd_valid, input snd_ready);
  modport slave  (input sound, input snd_valid, output snd_ready);

endinterface

// File: rtl/jt89_i2s_clkdiv.sv
// Bit clock generator for the jt89 I2S transmitter.
// bclk toggles every DIV clk cycles; fall is high for one cycle in the
// cycle where bclk is about to be driven 1->0, so that registers updated on
// fall change together with the bclk falling edge.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   bclk      generated bit clock (a data signal, not a clock)
//   fall      one-cycle strobe marking the bclk fall event
module jt89_i2s_clkdiv import jt89_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);

  localparam int            CW      = cnt_w(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CNT_MAX);
  assign fall = wrap & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jt89_i2s_tx.sv
// I2S transmitter for the PSG's signed 12-bit mixed output.
// One-entry sample buffer fed by a valid/ready handshake; the mono sample is
// MSB-aligned in a WORD-bit slot and sent on both left and right slots.
// Build option: define JT89_I2S_LJ_EN for left-justified output (no one-bit
// delay); otherwise standard I2S with the MSB one bclk after lrck changes.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   snd        sample handshake (slave side: sound, snd_valid, snd_ready)
//   bclk       I2S bit clock
//   lrck       word select, 0 = left slot, 1 = right slot
//   sdata      serial data, MSB first
//   underrun   one-cycle pulse when a frame starts with an empty buffer
module jt89_i2s_tx import jt89_pkg::*; #(
  parameter int DIV  = 2,
  parameter int WORD = 16
) (
  input  logic           clk,
  input  logic           rst,
  jt89_i2s_tx_if.slave   snd,
  output logic           bclk,
  output logic           lrck,
  output logic           sdata,
  output logic           underrun
);

  localparam int            KW     = idx_w(WORD);
  localparam logic [KW-1:0] K_LAST = KW'(2 * WORD - 1);
  localparam logic [KW-1:0] K_WORD = KW'(WORD);

  logic                    fall;
  logic signed [SND_W-1:0] sbuf;
  logic signed [SND_W-1:0] held;
  logic                    buf_full;
  logic [KW-1:0]           k;

  logic                    accept;
  logic                    frame_start;
  logic                    load;
  logic [KW-1:0]           pos;
  logic [KW-1:0]           q;
  logic signed [SND_W-1:0] src;
  logic [WORD-1:0]         wd;
  logic [WORD-1:0]         wd_sh;
  logic                    sdata_nxt;

  jt89_i2s_clkdiv #(.DIV(DIV)) u_clkdiv (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .fall (fall)
  );

  assign snd.snd_ready = ~buf_full;
  assign accept        = snd.snd_valid & ~buf_full;
  assign frame_start   = fall & (k == '0);
  // Load decision looks at the buffer before any same-cycle write.
  assign load          = frame_start & buf_full;

  // Select which frame bit goes out on this fall event.
  always_comb begin
    pos = '0;
    src = held;
`ifdef JT89_I2S_LJ_EN
    // Left-justified: the new frame's MSB leaves together with the lrck edge,
    // so at k==0 the incoming sample must be used directly.
    pos = k;
    src = load ? sbuf : held;
`else
    // One-bit delay: k==0 still carries the last bit of the frame just sent.
    pos = (k == '0) ? K_LAST : k - 1'b1;
    src = held;
`endif
    q = (pos >= K_WORD) ? pos - K_WORD : pos;
    wd = '0;
    wd[WORD-1 -: SND_W] = src;
    wd_sh = wd << q;
    sdata_nxt = wd_sh[WORD-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf     <= '0;
      held     <= '0;
      buf_full <= 1'b0;
      k        <= '0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start & ~buf_full;
      if (fall) begin
        k     <= (k == K_LAST) ? '0 : k + 1'b1;
        lrck  <= (k >= K_WORD);
        sdata <= sdata_nxt;
      end
      if (load) held <= sbuf;
      if (accept) begin
        sbuf     <= snd.sound;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt89_i2s_tx.sv
// Directed bench for jt89_i2s_tx at DIV=2, WORD=16 (fall events every 4 clk,
// frame start every 128 clk, first fall at clk edge 4 after reset release).
module tb_jt89_i2s_tx;
  import jt89_pkg::*;

`ifdef JT89_I2S_LJ_EN
  localparam int SH = 0;
`else
  localparam int SH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk, lrck, sdata, underrun;

  jt89_i2s_tx_if sif ();

  jt89_i2s_tx #(.DIV(2), .WORD(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .snd      (sif),
    .bclk     (bclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   k;
    logic lrck;
    logic sd_i2s;
    logic sd_lj;
  } vec_t;

  vec_t vt[12];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  initial begin
    int acc;
    int u;

    // Frame of 12'h801 -> slot 16'h8010, hand-computed at selected k.
    vt[0]  = '{0,  1'b0, 1'b0, 1'b1};
    vt[1]  = '{1,  1'b0, 1'b1, 1'b0};
    vt[2]  = '{2,  1'b0, 1'b0, 1'b0};
    vt[3]  = '{11, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{12, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{13, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{15, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{16, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{17, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{27, 1'b1, 1'b0, 1'b1};
    vt[10] = '{28, 1'b1, 1'b1, 1'b0};
    vt[11] = '{31, 1'b1, 1'b0, 1'b0};

    sif.sound     = '0;
    sif.snd_valid = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_bclk", bclk, 0);
      chk("rst_lrck", lrck, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_ready", sif.snd_ready, 1);
      chk("rst_underrun", underrun, 0);
    end

    // Release reset and offer 12'h801 before the first frame start.
    rst = 1'b0;
    cyc = 0;
    sif.sound     = 12'sh801;
    sif.snd_valid = 1'b1;
    tick();
    chk("acc801_ready", sif.snd_ready, 0);
    chk("bclk_e1", bclk, 0);
    sif.snd_valid = 1'b0;
    tick();
    chk("bclk_e2", bclk, 1);
    tick();
    chk("bclk_e3", bclk, 1);
    tick();
    chk("bclk_e4", bclk, 0);
    chk("load_ready", sif.snd_ready, 1);
    chk("first_underrun", underrun, 0);

    for (int i = 0; i < 12; i++) begin
      run_to(4 + 4 * vt[i].k);
      chk("tbl_lrck", lrck, vt[i].lrck);
`ifdef JT89_I2S_LJ_EN
      chk("tbl_sdata", sdata, vt[i].sd_lj);
`else
      chk("tbl_sdata", sdata, vt[i].sd_i2s);
`endif
    end

    // No new sample: underrun once per frame, 801 replays.
    run_to(132);
    chk("underrun_132", underrun, 1);
    u = 0;
    while (cyc < 260) begin
      tick();
      if (underrun) u++;
      if (cyc == 132 + 4 * (11 + SH)) chk("replay_q11", sdata, 1);
      if (cyc == 132 + 4 * (12 + SH)) chk("replay_q12", sdata, 0);
    end
    chk("underrun_count", u, 1);

    // snd_valid held high: one accept per frame.
    run_to(261);
    sif.sound     = 12'sh123;
    sif.snd_valid = 1'b1;
    tick();
    chk("acc123_ready", sif.snd_ready, 0);
    acc = 0;
    while (cyc < 516) begin
      if (sif.snd_valid && sif.snd_ready) acc++;
      tick();
      if (cyc == 388) begin
        chk("cont_underrun", underrun, 0);
        chk("cont_ready_up", sif.snd_ready, 1);
      end
      if (cyc == 389) chk("cont_ready_dn", sif.snd_ready, 0);
      if (cyc == 388 + 4 * (2 + SH)) chk("s123_q2", sdata, 0);
      if (cyc == 388 + 4 * (3 + SH)) chk("s123_q3", sdata, 1);
    end
    chk("accept_count", acc, 1);
    chk("ready_516", sif.snd_ready, 1);
    sif.snd_valid = 1'b0;

    // Accept coincident with a frame start on an empty buffer.
    run_to(643);
    sif.sound     = 12'sh7FF;
    sif.snd_valid = 1'b1;
    tick();
    chk("coin_underrun", underrun, 1);
    chk("coin_ready", sif.snd_ready, 0);
    sif.snd_valid = 1'b0;
    tick();
    chk("coin_pulse_end", underrun, 0);
    run_to(644 + 4 * (3 + SH));
    chk("coin_replay_q3", sdata, 1);
    run_to(772);
    chk("next_underrun", underrun, 0);
    chk("next_ready", sif.snd_ready, 1);
    run_to(772 + 4 * SH);
    chk("s7ff_q0", sdata, 0);
    chk("s7ff_lrck", lrck, 0);
    run_to(772 + 4 * (1 + SH));
    chk("s7ff_q1", sdata, 1);
    run_to(772 + 4 * (11 + SH));
    chk("s7ff_q11", sdata, 1);
    run_to(772 + 4 * (12 + SH));
    chk("s7ff_q12", sdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt89_i2s_tx.md
Name: jt89_i2s_tx

Overview:
- Serial transmitter on the consumer side of the PSG's signed 12-bit mixed sound output.
- Accepts one sample per valid/ready handshake into a one-entry buffer.
- Emits it as an I2S stream (bclk, lrck, sdata) to an external audio DAC; the mono sample is duplicated onto the left and right slots.
- Sits between the PSG mixer and the board-level DAC pins; all logic runs on clk, and bclk is a generated data signal, not a clock.

Parameters:
- DIV, 2, clk cycles per bclk half-period (≥1).
- WORD, 16, bits per channel slot (12..32); sample MSB-aligned, low WORD-12 bits zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sound  in  12  signed sample, two's complement
- snd_valid  in  1  sound valid this cycle
- snd_ready  out  1  buffer empty; accept when snd_valid&&snd_ready
- bclk  out  1  I2S bit clock
- lrck  out  1  word select: 0=left slot, 1=right slot
- sdata  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse: frame started with empty buffer

Behaviour:
- Reset values: bclk=0, lrck=0, sdata=0, snd_ready=1, underrun=0, divider cnt=0, bit index k=0, held sample=0, buffer empty.
- Reset mid-frame discards the buffer and the partial frame.
- Divider: cnt counts 0..DIV-1. On cnt==DIV-1, cnt wraps to 0 and bclk toggles.
  - A "fall event" is the cycle bclk is driven 1→0.
  - First fall event occurs 2*DIV cycles after rst deasserts.
- Bit index k (0..2*WORD-1) advances by one on each fall event and wraps to 0.
- lrck and sdata update only on fall events, so they are stable across bclk rising edges.
- Fall event with k==0 (frame start):
  - Buffer full: copy buffer to held sample, mark buffer empty.
  - Buffer empty: keep held sample (replay) and pulse underrun for that cycle.
  - The decision uses the buffer state before any same-cycle write.
- Handshake: snd_ready=1 while the buffer is empty.
  - Accept writes sound into the buffer; snd_ready drops the next cycle.
  - An accept in the same cycle as a frame-start load is kept: the buffer goes full with the new sample.
  - No overwrite while the buffer is full; the producer must hold snd_valid.
- Slot word: W = {sound, (WORD-12) zeros}; the frame is {W, W}.
- On the fall event at index k:
  - lrck <= (k >= WORD).
  - sdata <= frame bit (2*WORD-1 - ((k-1) mod 2*WORD)), MSB first.
  - This gives the standard one-bclk I2S delay: the MSB of the left slot appears at k=1.
  - At k=0, sdata carries the previous frame's final bit (0 when WORD>12).
- Frame period: 4*DIV*WORD clk cycles; the PSG's sample rate must not exceed this, or samples back up behind snd_ready.

Optional Feature:
- Macro JT89_I2S_LJ_EN.
- Defined: left-justified format, with no one-bit delay. sdata at index k = frame bit (2*WORD-1-k), so the MSB appears with the lrck transition.
- Undefined: standard I2S one-bit delay as above.
- lrck timing, the handshake and underrun are identical in both modes.

Decomposition:
- Package jt89_pkg: constant SND_W=12, a function for the divider width, and a function for the bit-index width.
- Sub-module jt89_i2s_clkdiv: the divider plus bclk generation. Outputs bclk and a one-cycle fall strobe; reset as above.
- The top level holds the buffer, held sample, bit index, lrck and sdata logic.

Test Plan:
- Reset, DIV=2: bclk first rises at clk 2 and falls at clk 4 after rst release. lrck=0, sdata=0, snd_ready=1 throughout reset.
- DIV=2, WORD=16, single accept of sound=12'h801: next left slot shifts 16'h8010 MSB first, starting at k=1. The right slot repeats it; lrck high for k=16..31.
- No sample supplied: underrun pulses once per frame (every 128 clk at DIV=2, WORD=16) and the last held sample replays.
- snd_valid held high continuously: exactly one accept per frame. snd_ready rises in the cycle after each frame-start load.
- Accept coincident with a frame-start fall event on an empty buffer: underrun pulses, and the new sample is transmitted in the following frame.
- JT89_I2S_LJ_EN defined, sound=12'h7FF: the MSB (0) appears at k=0 together with lrck=0, followed by eleven 1s and then four 0s.
